lpc_cycle_decoder: RTL
======================

Name: lpc_cycle_decoder

Overview:
- Passive LPC bus decoder. Generalises the single-byte I/O decoder to I/O and memory cycles in both directions, firmware-hub cycles of 1/2/4 bytes, SYNC wait-state tracking with a timeout, and abort detection.
- Sits between the sampled LPC pins and the sniffer output FIFO/UART. Emits one result record per completed cycle.

Parameters:
- MEM_ENABLE, 1, decode memory cycles (cyctype 01); 0 ignores them.
- FW_ENABLE, 1, decode firmware-hub starts 1101/1110; 0 ignores them.
- WAIT_LIMIT, 8, number of consecutive wait SYNCs (0101/0110) that causes a timeout.
- WAIT_W, 4, width of the wait counter; must hold WAIT_LIMIT.

Ports:
- lpc_clock  in  1  LPC clock; all logic on its rising edge.
- lpc_reset  in  1  asynchronous, active-high reset.
- lpc_ad  in  4  LAD[3:0].
- lpc_frame  in  1  LFRAME#, active-low.
- out_cyctype_dir  out  4  CT/DIR nibble for LPC cycles; the start nibble (1101/1110) for FW cycles.
- out_addr  out  32  I/O address zero-extended from 16 bits; memory address 32 bits; FW address {IDSEL, 28-bit addr}.
- out_data  out  32  data, little-endian bytes, unused bytes zero.
- out_data_size  out  4  byte count: 1, 2 or 4.
- out_sync_error  out  1  last committed cycle ended with SYNC 1010.
- out_wait_count  out  WAIT_W  wait SYNCs seen in the last committed cycle.
- out_clock_enable  out  1  one-cycle commit strobe.
- out_abort  out  1  one-cycle pulse on abort.
- out_sync_timeout  out  1  one-cycle pulse on wait timeout.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters cleared. Reset asserted mid-cycle discards the cycle with no strobe.
- Start detection:
  - Any clock with lpc_frame=0 samples lpc_ad as a start nibble; while frame stays low, the last nibble wins.
  - 0000 leads to CTDIR. 1101/1110 with FW_ENABLE lead to IDSEL.
  - Any other nibble leads to IGNORE, which waits for the next frame-low.
- CTDIR: bits [3:2] 00 = I/O, 01 = memory (needs MEM_ENABLE); bit 1 = direction (1 = write). DMA, bus-master or disabled types go to IGNORE.
- Address: nibbles MSB first. I/O takes 4 nibbles, memory 8. FW takes 1 IDSEL nibble, then 7 address nibbles, then MSIZE (0000=1, 0001=2, 0010=4 bytes; other values go to IGNORE).
- Write order: ADDR, DATA (2 nibbles per byte, low nibble first), TAR (2 clocks), SYNC, TAR (2).
- Read order: ADDR, TAR (2), SYNC, DATA, TAR (2).
- SYNC:
  - 0000 = ready.
  - 1010 = ready with error; set the error flag.
  - 0101 or 0110 = wait: stay in SYNC and increment the wait counter. When the counter reaches WAIT_LIMIT, pulse out_sync_timeout and go to IDLE.
  - Any other value: go to IDLE silently.
- Commit point: ready SYNC for writes; final data nibble for reads.
  - All result outputs load and out_clock_enable=1 on the following clock, for exactly 1 cycle.
  - Outputs hold until the next commit.
- Trailing TAR: the FSM tracks both TAR nibbles. The clock immediately after the second one must accept a new start; back-to-back cycles need 0 idle clocks.
- Abort: lpc_frame=0 in any state other than IDLE/START/IGNORE/trailing TAR.
  - Pulse out_abort, suppress the commit, and treat the current nibble as a start nibble.
  - If the commit strobe is already registered, it is still delivered; abort applies only to the in-flight cycle.
- Simultaneous commit strobe and abort pulse on the same cycle are legal.
- Wait counter saturates at WAIT_LIMIT and clears at each start.

Test Plan:
- Back-to-back I/O reads, 0x7FE4/0x6B then 0x7FE5/0x6C, no idle clocks → two strobes. Each record: ct_dir=0000, size=1, wait=0, matching addr/data.
- I/O write 0x0080←0xA5 with 3 long-wait SYNCs then 0000 → one strobe: ct_dir=0010, addr=0x80, data=0xA5, wait=3.
- Memory read 0xFFFF_FFF0 with SYNC 1010 → strobe with sync_error=1. Repeat with MEM_ENABLE=0 → no strobe.
- FW read, IDSEL=0, addr 0xFFFFFF0, MSIZE=0010, bytes 11 22 33 44 → addr=0x0FFFFFF0, data=0x44332211, size=4, ct_dir=1101.
- WAIT_LIMIT=4 with endless 0110 SYNCs → out_sync_timeout pulses once after the 4th wait, no strobe. Next I/O read then decodes correctly.
- lpc_frame pulled low during the 2nd address nibble → out_abort pulse, no strobe. Separately, reset asserted mid-data → all outputs 0, then normal decode of the next cycle.

Source files
------------

// File: rtl/lpc_cycle_decoder_if.sv
// LPC sniffer bus bundle: sampled LAD/LFRAME# pins in, decoded cycle record out.
// master = whatever drives the pins (board sampler or bench), slave = the decoder.
interface lpc_cycle_decoder_if #(
    parameter int WAIT_W = 4
) ();
    logic [3:0]        lpc_ad;
    logic              lpc_frame;
    logic [3:0]        out_cyctype_dir;
    logic [31:0]       out_addr;
    logic [31:0]       out_data;
    logic [3:0]        out_data_size;
    logic              out_sync_error;
    logic [WAIT_W-1:0] out_wait_count;
    logic              out_clock_enable;
    logic              out_abort;
    logic              out_sync_timeout;

    modport master (
        output lpc_ad, lpc_frame,
        input  out_cyctype_dir, out_addr, out_data, out_data_size, out_sync_error,
        input  out_wait_count, out_clock_enable, out_abort, out_sync_timeout
    );

    modport slave (
        input  lpc_ad, lpc_frame,
        output out_cyctype_dir, out_addr, out_data, out_data_size, out_sync_error,
        output out_wait_count, out_clock_enable, out_abort, out_sync_timeout
    );
endinterface

// File: rtl/lpc_cycle_decoder.sv
// Passive LPC cycle decoder: follows I/O, memory and firmware-hub cycles on the
// sampled LAD/LFRAME# pins and emits one record per completed cycle, plus
// one-clock pulses for aborted cycles and SYNC wait timeouts.
module lpc_cycle_decoder #(
    parameter int MEM_ENABLE = 1,
    parameter int FW_ENABLE  = 1,
    parameter int WAIT_LIMIT = 8,
    parameter int WAIT_W     = 4
) (
    input  logic               lpc_clock,
    input  logic               lpc_reset,
    lpc_cycle_decoder_if.slave bus
);

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_START  = 4'd1;
    localparam logic [3:0] ST_IGNORE = 4'd2;
    localparam logic [3:0] ST_ADDR   = 4'd3;
    localparam logic [3:0] ST_MSIZE  = 4'd4;
    localparam logic [3:0] ST_WDATA  = 4'd5;
    localparam logic [3:0] ST_WTAR   = 4'd6;
    localparam logic [3:0] ST_RTAR   = 4'd7;
    localparam logic [3:0] ST_SYNC   = 4'd8;
    localparam logic [3:0] ST_RDATA  = 4'd9;
    localparam logic [3:0] ST_TTAR   = 4'd10;

    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(WAIT_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    logic [3:0]        state;
    logic [3:0]        start_nib;
    logic [3:0]        ctdir;
    logic              is_fw;
    logic              is_write;
    logic [31:0]       addr_reg;
    logic [31:0]       data_reg;
    logic [2:0]        size_reg;
    logic [3:0]        nib_cnt;
    logic              tar_second;
    logic              err_flag;
    logic [WAIT_W-1:0] wait_cnt;

    logic [3:0]        res_ctdir;
    logic [31:0]       res_addr;
    logic [31:0]       res_data;
    logic [3:0]        res_size;
    logic              res_err;
    logic [WAIT_W-1:0] res_wait;
    logic              res_strobe;
    logic              res_abort;
    logic              res_timeout;

    logic [31:0]       data_ins;
    logic [3:0]        last_idx;
    logic              in_frame_ok_state;

    assign bus.out_cyctype_dir  = res_ctdir;
    assign bus.out_addr         = res_addr;
    assign bus.out_data         = res_data;
    assign bus.out_data_size    = res_size;
    assign bus.out_sync_error   = res_err;
    assign bus.out_wait_count   = res_wait;
    assign bus.out_clock_enable = res_strobe;
    assign bus.out_abort        = res_abort;
    assign bus.out_sync_timeout = res_timeout;

    // Data word with the current LAD nibble merged at the current nibble slot
    // (byte-little-endian, low nibble first), plus the index of the last nibble.
    always_comb begin
        data_ins = data_reg;
        data_ins[{nib_cnt[2:0], 2'b00} +: 4] = bus.lpc_ad;
        last_idx = {size_reg, 1'b0} - 4'd1;
        in_frame_ok_state = (state == ST_IDLE) || (state == ST_START) ||
                            (state == ST_IGNORE) || (state == ST_TTAR);
    end

    // Cycle-tracking FSM and result registers; LFRAME# low always restarts
    // decoding, and counts as an abort when it interrupts a cycle in flight.
    always_ff @(posedge lpc_clock or posedge lpc_reset) begin
        if (lpc_reset) begin
            state       <= ST_IDLE;
            start_nib   <= 4'd0;
            ctdir       <= 4'd0;
            is_fw       <= 1'b0;
            is_write    <= 1'b0;
            addr_reg    <= 32'd0;
            data_reg    <= 32'd0;
            size_reg    <= 3'd0;
            nib_cnt     <= 4'd0;
            tar_second  <= 1'b0;
            err_flag    <= 1'b0;
            wait_cnt    <= '0;
            res_ctdir   <= 4'd0;
            res_addr    <= 32'd0;
            res_data    <= 32'd0;
            res_size    <= 4'd0;
            res_err     <= 1'b0;
            res_wait    <= '0;
            res_strobe  <= 1'b0;
            res_abort   <= 1'b0;
            res_timeout <= 1'b0;
        end else begin
            res_strobe  <= 1'b0;
            res_abort   <= 1'b0;
            res_timeout <= 1'b0;
            if (!bus.lpc_frame) begin
                if (!in_frame_ok_state) begin
                    res_abort <= 1'b1;
                end
                state     <= ST_START;
                start_nib <= bus.lpc_ad;
                wait_cnt  <= '0;
                err_flag  <= 1'b0;
                addr_reg  <= 32'd0;
                data_reg  <= 32'd0;
            end else begin
                case (state)
                    ST_START: begin
                        if (start_nib == 4'b0000) begin
                            ctdir    <= bus.lpc_ad;
                            is_fw    <= 1'b0;
                            is_write <= bus.lpc_ad[1];
                            size_reg <= 3'd1;
                            if (bus.lpc_ad[3:2] == 2'b00) begin
                                nib_cnt <= 4'd4;
                                state   <= ST_ADDR;
                            end else if (bus.lpc_ad[3:2] == 2'b01 && MEM_ENABLE != 0) begin
                                nib_cnt <= 4'd8;
                                state   <= ST_ADDR;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end else if (FW_ENABLE != 0 &&
                                     (start_nib == 4'b1101 || start_nib == 4'b1110)) begin
                            ctdir    <= start_nib;
                            is_fw    <= 1'b1;
                            is_write <= (start_nib == 4'b1110);
                            addr_reg <= {28'd0, bus.lpc_ad};
                            nib_cnt  <= 4'd7;
                            state    <= ST_ADDR;
                        end else begin
                            state <= ST_IGNORE;
                        end
                    end
                    ST_ADDR: begin
                        addr_reg <= {addr_reg[27:0], bus.lpc_ad};
                        nib_cnt  <= nib_cnt - 4'd1;
                        if (nib_cnt == 4'd1) begin
                            if (is_fw) begin
                                state <= ST_MSIZE;
                            end else if (is_write) begin
                                nib_cnt <= 4'd0;
                                state   <= ST_WDATA;
                            end else begin
                                tar_second <= 1'b0;
                                state      <= ST_RTAR;
                            end
                        end
                    end
                    ST_MSIZE: begin
                        nib_cnt    <= 4'd0;
                        tar_second <= 1'b0;
                        state      <= is_write ? ST_WDATA : ST_RTAR;
                        case (bus.lpc_ad)
                            4'b0000: size_reg <= 3'd1;
                            4'b0001: size_reg <= 3'd2;
                            4'b0010: size_reg <= 3'd4;
                            default: state <= ST_IGNORE;
                        endcase
                    end
                    ST_WDATA: begin
                        data_reg <= data_ins;
                        if (nib_cnt == last_idx) begin
                            tar_second <= 1'b0;
                            state      <= ST_WTAR;
                        end else begin
                            nib_cnt <= nib_cnt + 4'd1;
                        end
                    end
                    ST_WTAR, ST_RTAR: begin
                        if (tar_second) begin
                            state <= ST_SYNC;
                        end else begin
                            tar_second <= 1'b1;
                        end
                    end
                    ST_SYNC: begin
                        case (bus.lpc_ad)
                            4'b0000, 4'b1010: begin
                                if (is_write) begin
                                    res_ctdir  <= ctdir;
                                    res_addr   <= addr_reg;
                                    res_data   <= data_reg;
                                    res_size   <= {1'b0, size_reg};
                                    res_err    <= (bus.lpc_ad == 4'b1010);
                                    res_wait   <= wait_cnt;
                                    res_strobe <= 1'b1;
                                    tar_second <= 1'b0;
                                    state      <= ST_TTAR;
                                end else begin
                                    err_flag <= (bus.lpc_ad == 4'b1010);
                                    nib_cnt  <= 4'd0;
                                    state    <= ST_RDATA;
                                end
                            end
                            4'b0101, 4'b0110: begin
                                if (wait_cnt != WAIT_MAX) begin
                                    wait_cnt <= wait_cnt + WAIT_ONE;
                                end
                                if (wait_cnt >= WAIT_LAST) begin
                                    res_timeout <= 1'b1;
                                    state       <= ST_IDLE;
                                end
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                    ST_RDATA: begin
                        data_reg <= data_ins;
                        if (nib_cnt == last_idx) begin
                            res_ctdir  <= ctdir;
                            res_addr   <= addr_reg;
                            res_data   <= data_ins;
                            res_size   <= {1'b0, size_reg};
                            res_err    <= err_flag;
                            res_wait   <= wait_cnt;
                            res_strobe <= 1'b1;
                            tar_second <= 1'b0;
                            state      <= ST_TTAR;
                        end else begin
                            nib_cnt <= nib_cnt + 4'd1;
                        end
                    end
                    ST_TTAR: begin
                        if (tar_second) begin
                            state <= ST_IDLE;
                        end else begin
                            tar_second <= 1'b1;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

endmodule
